// File: rtl/uart_rx_os.sv
// UART receiver: 16x oversampling, 3-sample majority vote, runtime frame format,
// break detection, error-tagged FWFT receive FIFO, CTS flow control, idle timeout.
module uart_rx_os #(
    parameter int FIFO_DEPTH    = 8,
    parameter int OS_RATE       = 16,
    parameter int CTS_THRESHOLD = FIFO_DEPTH - 2,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick_os_i,
    input  logic                          rx_i,
    input  logic                          rx_enable_i,
    input  logic [1:0]                    cfg_data_bits_i,
    input  logic [1:0]                    cfg_parity_i,
    input  logic                          cfg_stop2_i,
    input  logic                          flush_i,
    output logic [7:0]                    rx_d_o,
    output logic [2:0]                    rx_err_o,
    output logic                          rx_d_valid_o,
    input  logic                          rx_d_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
    output logic                          rx_cts_n_o,
    output logic                          overrun_o,
    output logic                          timeout_o,
    output logic                          wakeup_o
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int TW     = $clog2(OS_RATE);
    localparam int TO_LIM = TIMEOUT_CHARS * 10 * OS_RATE;
    localparam int OW     = $clog2(TO_LIM + 1);

    localparam logic [TW-1:0] TC_S0  = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] TC_S1  = TW'(OS_RATE / 2);
    localparam logic [TW-1:0] TC_DEC = TW'(OS_RATE / 2 + 1);
    localparam logic [TW-1:0] TC_END = TW'(OS_RATE - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_CTS  = LW'(CTS_THRESHOLD);
    localparam logic [OW-1:0] TO_LAST  = OW'(TO_LIM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK
    } state_e;

    state_e state_q, state_d;

    logic [1:0]    sync_q;
    logic          rx_s;
    logic [TW-1:0] tc_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    data_q;
    logic          s0_q, s1_q;
    logic          perr_q, parbit_q, frame_q;
    logic [1:0]    cfg_bits_q, cfg_par_q;
    logic          cfg_stop2_q;

    logic          maj, dec, bit_end, start_det;
    logic          par_en, last_bit, brk, perr_d;
    logic          push;
    logic [10:0]   push_word;

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          ovr_q, cts_q, to_q;
    logic [OW-1:0] to_cnt_q;
    logic          full, pop, do_push, do_pop;
    logic [10:0]   head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx_i};
    end
    assign rx_s = sync_q[1];

    assign maj       = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    assign dec       = tick_os_i & (tc_q == TC_DEC);
    assign bit_end   = tick_os_i & (tc_q == TC_END);
    assign start_det = tick_os_i & rx_enable_i & (state_q == S_IDLE) & ~rx_s;
    assign par_en    = ^cfg_par_q;
    assign last_bit  = bitcnt_q == (3'd4 + {1'b0, cfg_bits_q});
    assign brk       = (data_q == 8'h00) & ~(par_en & parbit_q) & ~maj;
    assign perr_d    = (^data_q) ^ maj ^ (cfg_par_q == 2'b10);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!rx_enable_i) begin
            state_d = S_IDLE;
        end else if (tick_os_i) begin
            unique case (state_q)
                S_IDLE:   if (!rx_s) state_d = S_START;
                S_START: begin
                    if (dec && maj)   state_d = S_IDLE;
                    else if (bit_end) state_d = S_DATA;
                end
                S_DATA: begin
                    if (bit_end && last_bit)
                        state_d = par_en ? S_PARITY : S_STOP1;
                end
                S_PARITY: if (bit_end) state_d = S_STOP1;
                S_STOP1: begin
                    if (dec && brk)               state_d = S_BRK;
                    else if (dec && !cfg_stop2_q) state_d = S_IDLE;
                    else if (bit_end)             state_d = S_STOP2;
                end
                S_STOP2:  if (dec) state_d = S_IDLE;
                S_BRK:    if (rx_s) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output logic: character push on the stop-bit decision tick
    always_comb begin
        push      = 1'b0;
        push_word = {1'b0, ~maj, perr_q, data_q};
        unique case (state_q)
            S_STOP1: begin
                if (dec && (brk || !cfg_stop2_q)) push = rx_enable_i;
                if (brk) push_word = {2'b11, perr_q, 8'h00};
            end
            S_STOP2: begin
                push      = dec & rx_enable_i;
                push_word = {1'b0, frame_q | ~maj, perr_q, data_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q        <= '0;
            bitcnt_q    <= '0;
            data_q      <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            perr_q      <= 1'b0;
            parbit_q    <= 1'b0;
            frame_q     <= 1'b0;
            cfg_bits_q  <= '0;
            cfg_par_q   <= '0;
            cfg_stop2_q <= 1'b0;
        end else if (start_det) begin
            tc_q        <= TW'(1);
            bitcnt_q    <= '0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            parbit_q    <= 1'b0;
            frame_q     <= 1'b0;
            cfg_bits_q  <= cfg_data_bits_i;
            cfg_par_q   <= cfg_parity_i;
            cfg_stop2_q <= cfg_stop2_i;
        end else if (tick_os_i && state_q != S_IDLE && state_q != S_BRK) begin
            tc_q <= (tc_q == TC_END) ? '0 : tc_q + 1'b1;
            if (tc_q == TC_S0) s0_q <= rx_s;
            if (tc_q == TC_S1) s1_q <= rx_s;
            if (dec) begin
                unique case (state_q)
                    S_DATA:   data_q[bitcnt_q] <= maj;
                    S_PARITY: begin
                        perr_q   <= perr_d;
                        parbit_q <= maj;
                    end
                    S_STOP1:  frame_q <= ~maj;
                    default: ;
                endcase
            end
            if (bit_end && state_q == S_DATA && !last_bit)
                bitcnt_q <= bitcnt_q + 1'b1;
        end
    end

    assign wakeup_o = state_q != S_IDLE;

    assign full    = level_q == LVL_FULL;
    assign pop     = rx_d_valid_o & rx_d_ready_i;
    assign do_push = push & ~flush_i & (~full | pop);
    assign do_pop  = pop & ~flush_i;
    assign head    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
            if (push && full && !pop) ovr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cts_q <= 1'b1;
        else        cts_q <= ~rx_enable_i | (level_q >= LVL_CTS);
    end

    // Idle timeout counts ticks only while idle with data waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else if (flush_i || pop || start_det) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else if (tick_os_i && state_q == S_IDLE && level_q != '0 && !to_q) begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) to_q <= 1'b1;
        end
    end

    assign rx_d_valid_o = level_q != '0;
    assign rx_d_o       = rx_d_valid_o ? head[7:0] : 8'h00;
    assign rx_err_o     = rx_d_valid_o ? head[10:8] : 3'b000;
    assign rx_level_o   = level_q;
    assign rx_cts_n_o   = cts_q;
    assign overrun_o    = ovr_q;
    assign timeout_o    = to_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames driven bit by bit, results
// checked as they leave the receive FIFO.
module tb_uart_rx_os;

    localparam int OS = 16;

    typedef struct {
        logic [7:0] d;
        logic [2:0] e;
        logic [2:0] m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_os_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_enable_i = 1'b1;
    logic [1:0] cfg_data_bits_i = 2'b11;
    logic [1:0] cfg_parity_i = 2'b00;
    logic       cfg_stop2_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       rx_d_ready_i = 1'b0;
    logic [7:0] rx_d_o;
    logic [2:0] rx_err_o;
    logic       rx_d_valid_o;
    logic [3:0] rx_level_o;
    logic       rx_cts_n_o;
    logic       overrun_o;
    logic       timeout_o;
    logic       wakeup_o;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t e;

    uart_rx_os dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick_os_i       (tick_os_i),
        .rx_i            (rx_i),
        .rx_enable_i     (rx_enable_i),
        .cfg_data_bits_i (cfg_data_bits_i),
        .cfg_parity_i    (cfg_parity_i),
        .cfg_stop2_i     (cfg_stop2_i),
        .flush_i         (flush_i),
        .rx_d_o          (rx_d_o),
        .rx_err_o        (rx_err_o),
        .rx_d_valid_o    (rx_d_valid_o),
        .rx_d_ready_i    (rx_d_ready_i),
        .rx_level_o      (rx_level_o),
        .rx_cts_n_o      (rx_cts_n_o),
        .overrun_o       (overrun_o),
        .timeout_o       (timeout_o),
        .wakeup_o        (wakeup_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rx_d_valid_o && rx_d_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexp_pop", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rx_d", {24'd0, rx_d_o}, {24'd0, e.d});
                chk("rx_err", {29'd0, rx_err_o & e.m}, {29'd0, e.e & e.m});
            end
        end
    end

    task automatic exp_push(input logic [7:0] d, input logic [2:0] er,
                            input logic [2:0] m);
        exp_t x;
        x.d = d;
        x.e = er;
        x.m = m;
        exp_q.push_back(x);
    endtask

    // One oversample tick occupies two clock cycles
    task automatic tick_n(input int n);
        repeat (n) begin
            tick_os_i = 1'b1;
            @(posedge clk); #1;
            tick_os_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bit(input logic v, input bit noise);
        for (int t = 0; t < OS; t++) begin
            rx_i = (noise && t == OS / 2) ? ~v : v;
            tick_n(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb,
                              input logic [1:0] pm, input bit two,
                              input bit pflip, input logic s2v,
                              input bit noise);
        logic p;
        p = (pm == 2'b10);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nb; i++) begin
            send_bit(d[i], noise);
            p = p ^ d[i];
        end
        if (pm == 2'b01 || pm == 2'b10) send_bit(p ^ pflip, 1'b0);
        send_bit(1'b1, 1'b0);
        if (two) send_bit(s2v, 1'b0);
        rx_i = 1'b1;
        tick_n(16);
    endtask

    task automatic pop_one();
        rx_d_ready_i = 1'b1;
        @(posedge clk); #1;
        rx_d_ready_i = 1'b0;
    endtask

    initial begin
        #22;
        chk("rst_valid", {31'd0, rx_d_valid_o}, 32'd0);
        chk("rst_level", {28'd0, rx_level_o}, 32'd0);
        chk("rst_cts", {31'd0, rx_cts_n_o}, 32'd1);
        chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
        chk("rst_to", {31'd0, timeout_o}, 32'd0);
        chk("rst_wake", {31'd0, wakeup_o}, 32'd0);
        chk("rst_d", {24'd0, rx_d_o}, 32'd0);
        chk("rst_err", {29'd0, rx_err_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick_n(20);

        // 8N1 basic character
        exp_push(8'hA5, 3'b000, 3'b111);
        send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5_level", {28'd0, rx_level_o}, 32'd1);
        chk("a5_cts", {31'd0, rx_cts_n_o}, 32'd0);
        pop_one();
        chk("a5_empty", {28'd0, rx_level_o}, 32'd0);

        // 7E2: bad parity, then bad second stop
        cfg_data_bits_i = 2'b10;
        cfg_parity_i    = 2'b01;
        cfg_stop2_i     = 1'b1;
        exp_push(8'h3C, 3'b001, 3'b111);
        send_frame(8'h3C, 7, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
        pop_one();
        exp_push(8'h3C, 3'b010, 3'b111);
        send_frame(8'h3C, 7, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(32);
        chk("s2_level", {28'd0, rx_level_o}, 32'd1);
        pop_one();

        // 8N1 short glitch and per-bit noise
        cfg_data_bits_i = 2'b11;
        cfg_parity_i    = 2'b00;
        cfg_stop2_i     = 1'b0;
        rx_i = 1'b0;
        tick_n(4);
        rx_i = 1'b1;
        tick_n(32);
        chk("glitch_lvl", {28'd0, rx_level_o}, 32'd0);
        chk("glitch_wake", {31'd0, wakeup_o}, 32'd0);
        exp_push(8'h55, 3'b000, 3'b111);
        send_frame(8'h55, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        pop_one();

        // Break: line low for 20 bit times
        exp_push(8'h00, 3'b110, 3'b110);
        rx_i = 1'b0;
        tick_n(20 * OS);
        chk("brk_level", {28'd0, rx_level_o}, 32'd1);
        chk("brk_wake", {31'd0, wakeup_o}, 32'd1);
        rx_i = 1'b1;
        tick_n(8);
        chk("brk_idle", {31'd0, wakeup_o}, 32'd0);
        chk("brk_level2", {28'd0, rx_level_o}, 32'd1);
        pop_one();
        exp_push(8'h12, 3'b000, 3'b111);
        send_frame(8'h12, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        pop_one();

        // FIFO fill, CTS, overrun, flush
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_push(8'h30 + 8'(i), 3'b000, 3'b111);
            send_frame(8'h30 + 8'(i), 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 4) chk("cts_lvl5", {31'd0, rx_cts_n_o}, 32'd0);
            if (i == 5) chk("cts_lvl6", {31'd0, rx_cts_n_o}, 32'd1);
        end
        chk("full_level", {28'd0, rx_level_o}, 32'd8);
        chk("full_ovr", {31'd0, overrun_o}, 32'd1);
        chk("full_cts", {31'd0, rx_cts_n_o}, 32'd1);
        pop_one();
        pop_one();
        chk("pop2_level", {28'd0, rx_level_o}, 32'd6);
        chk("ovr_sticky", {31'd0, overrun_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("fl_level", {28'd0, rx_level_o}, 32'd0);
        chk("fl_ovr", {31'd0, overrun_o}, 32'd0);
        chk("fl_cts", {31'd0, rx_cts_n_o}, 32'd0);

        // Idle timeout
        exp_push(8'h5A, 3'b000, 3'b111);
        send_frame(8'h5A, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(500);
        chk("to_early", {31'd0, timeout_o}, 32'd0);
        tick_n(200);
        chk("to_set", {31'd0, timeout_o}, 32'd1);
        pop_one();
        chk("to_clr", {31'd0, timeout_o}, 32'd0);

        // Disable mid-frame
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("dis_wake_mid", {31'd0, wakeup_o}, 32'd1);
        rx_enable_i = 1'b0;
        rx_i = 1'b1;
        @(posedge clk); #1;
        chk("dis_wake", {31'd0, wakeup_o}, 32'd0);
        @(posedge clk); #1;
        chk("dis_cts", {31'd0, rx_cts_n_o}, 32'd1);
        tick_n(200);
        rx_enable_i = 1'b1;
        tick_n(32);
        chk("dis_level", {28'd0, rx_level_o}, 32'd0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Next-generation UART receiver with 16x oversampling and 3-sample majority voting. Supports runtime-configurable character format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. Has break detection, a per-character error-tagged receive FIFO, threshold-based CTS flow control and an idle-timeout flag. Single clock domain; bit timing comes from a 1-cycle tick_os_i enable driven by the shared baud generator.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries (power of 2, >=2)
OS_RATE, 16, ticks per bit (even, >=8)
CTS_THRESHOLD, FIFO_DEPTH-2, FIFO level at which rx_cts_n_o deasserts
TIMEOUT_CHARS, 4, idle character times before timeout_o asserts

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tick_os_i  in  1  oversample enable, 1-cycle pulse, OS_RATE per bit
rx_i  in  1  serial input, asynchronous
rx_enable_i  in  1  receiver enable
cfg_data_bits_i  in  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity_i  in  2  00/11=none, 01=even, 10=odd
cfg_stop2_i  in  1  1 = two stop bits checked
flush_i  in  1  clears FIFO, overrun_o, timeout counter
rx_d_o  out  8  FIFO head data, LSB-aligned, unused MSBs 0
rx_err_o  out  3  FIFO head flags {break, frame, parity}
rx_d_valid_o  out  1  FIFO non-empty
rx_d_ready_i  in  1  pop when valid & ready
rx_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
rx_cts_n_o  out  1  flow control, active-low
overrun_o  out  1  sticky: character dropped because FIFO full
timeout_o  out  1  idle timeout with FIFO non-empty
wakeup_o  out  1  high while FSM not in IDLE

Behaviour:
- Reset: all outputs 0 except rx_cts_n_o=1. Sync flops=1. FSM=IDLE. FIFO empty.
- rx_i passes through a 2-flop synchronizer (rx_s). All FSM activity advances only on cycles with tick_os_i=1. Tick counter tc runs 0..OS_RATE-1 within each bit.
- Sampling: samples taken at tc = OS_RATE/2-1, OS_RATE/2, OS_RATE/2+1. Bit value = majority of the 3 samples. Decision made at tc=OS_RATE/2+1.
- IDLE: on tick with rx_enable_i & rx_s=0 -> START, tc=0 (this tick is tc=0).
- START: at decision, majority=1 -> false start, back to IDLE. Else continue to tc=OS_RATE-1, then DATA.
- DATA: shifts bits LSB first; the bit counter counts to the configured width. PARITY if parity is enabled, else STOP1.
- PARITY: parity_err = (XOR(data)^bit) != 0 for even, ==0 for odd.
- STOP1: acts at its decision point, without waiting for bit end, so resync is early.
  - If cfg_stop2_i=1: waits to tc=OS_RATE-1, then STOP2.
  - Otherwise pushes the character.
- STOP2: pushes at its decision point.
- frame flag = any checked stop sample 0.
- break flag = data all 0, parity bit 0 (if enabled) and STOP1 0.
  - On break, push data 0x00 with flags {1,1,x}, then BREAK_WAIT.
  - BREAK_WAIT stays until rx_s=1 on a tick, then IDLE.
- After a normal push: IDLE. A new start may be detected on the next tick.
- Push: occurs on the decision tick cycle. The entry is visible on rx_d_o one cycle later.
- FIFO: synchronous, first-word-fall-through; width 11 = data + flags. Pop on rx_d_valid_o & rx_d_ready_i.
  - Simultaneous push+pop when full: both occur, no overrun.
  - Push when full without pop: character dropped, overrun_o=1 until flush_i.
  - Pointers wrap modulo FIFO_DEPTH; full/empty decided via level counter.
- Config inputs are sampled at START entry and held for the frame.
- rx_enable_i=0: FSM forced to IDLE next cycle, in-progress frame discarded (no push). FIFO contents are kept.
- flush_i: empties the FIFO and clears overrun_o and timeout_o in one cycle. The FSM is unaffected. A push in the same cycle is discarded.
- rx_cts_n_o (registered) = ~rx_enable_i | (level >= CTS_THRESHOLD).
- Timeout: counter counts ticks while FSM=IDLE and FIFO non-empty. It resets on start detection, pop, or flush.
  - At TIMEOUT_CHARS*10*OS_RATE ticks, timeout_o=1 and holds until pop, flush or start.

Test Plan:
- 8N1, send 0xA5 with OS_RATE ticks per bit -> one entry, rx_d_o=0xA5, rx_err_o=000, level=1.
- 7E2, send 0x3C with wrong parity bit -> rx_d_o=0x3C, rx_err_o=001. Then send 0x3C with second stop bit 0 -> rx_err_o=010.
- 8N1 glitch: rx low for 4 ticks only -> false start, no push. Then single-sample noise inside 0x55 data bits -> still 0x55 received.
- Line held low for 20 bit times -> exactly one entry 0x00 with flags 11x. Nothing further until line returns high, then a 0x12 frame is received normally.
- FIFO_DEPTH=8, ready=0, send 9 chars -> level=8, overrun_o=1, ninth dropped. rx_cts_n_o=1 from level 6. flush_i -> level=0, overrun_o=0, rx_cts_n_o=0.
- Send 1 char, stay idle for 640 ticks -> timeout_o=1; pop -> timeout_o=0. Deassert rx_enable_i mid-frame -> no push, FSM in IDLE.
